// File: rtl/clk_en_ctrl.sv
// clk_en_ctrl
//   Runtime-programmable generator for the core clock-enable. It produces a
//   periodic enable that is high for the first HIGH phases of every period of
//   DIV+1 clk cycles. New DIV/HIGH values only take effect on a period boundary.
//   A debug halt/single-step handshake can freeze the enable between periods.
//
// Ports
//   clk           reference clock; the whole core runs on it
//   rst_n         asynchronous active-low reset
//   cfg_valid     a new DIV/HIGH pair is offered
//   cfg_ready     controller can accept a configuration this cycle
//   cfg_div       requested DIV   (period = DIV+1 cycles)
//   cfg_high      requested HIGH  (leading enabled phases per period)
//   halt_req      level; halt at the end of the current period
//   halt_ack      high while halted
//   step_req      pulse; run exactly one period while halted
//   clk_en        core clock enable
//   period_start  one-cycle pulse in phase 0 of each executed period
//   running       high while periods are being executed
//
// All outputs are registered and describe the phase of the cycle in which
// they are observed.

module clk_en_ctrl #(
  parameter int CNT_W        = 16,
  parameter int DEFAULT_DIV  = 4,
  parameter int DEFAULT_HIGH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CNT_W-1:0] cfg_div,
  input  logic [CNT_W-1:0] cfg_high,
  input  logic             halt_req,
  output logic             halt_ack,
  input  logic             step_req,
  output logic             clk_en,
  output logic             period_start,
  output logic             running
);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_HALTED = 2'd1,
    ST_STEP   = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] DIV_RST  = CNT_W'(DEFAULT_DIV);
  localparam logic [CNT_W-1:0] HIGH_RST = CNT_W'(DEFAULT_HIGH);
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

  // Registers describing the cycle currently being observed.
  state_t           state_q,     state_d;
  logic [CNT_W-1:0] phase_q,     phase_d;
  logic [CNT_W-1:0] div_q,       div_d;
  logic [CNT_W-1:0] high_q,      high_d;
  logic             stg_valid_q, stg_valid_d;
  logic [CNT_W-1:0] stg_div_q,   stg_div_d;
  logic [CNT_W-1:0] stg_high_q,  stg_high_d;
  // active_q is low only while in reset and until the first edge after it;
  // that edge behaves like a period boundary so the next cycle is phase 0.
  logic             active_q;

  // Registered outputs, computed from the next-cycle state.
  logic clk_en_d, period_start_d, running_d, halt_ack_d, cfg_ready_d;

  logic accept;
  logic boundary;

  assign accept   = cfg_valid && cfg_ready;
  assign boundary = !active_q || (state_q != ST_HALTED && phase_q == div_q);

  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    div_d       = div_q;
    high_d      = high_q;
    stg_valid_d = stg_valid_q;
    stg_div_d   = stg_div_q;
    stg_high_d  = stg_high_q;

    if (active_q && state_q == ST_HALTED) begin
      // Nothing is executing, so a new config can be applied immediately.
      phase_d = '0;
      if (accept) begin
        div_d  = cfg_div;
        high_d = cfg_high;
      end
      // Releasing the halt has priority over a step request in the same cycle.
      if (!halt_req) begin
        state_d = ST_RUN;
      end else if (step_req) begin
        state_d = ST_STEP;
      end
    end else if (boundary) begin
      // Last phase of a period: a config offered right now goes straight into
      // the next period; otherwise any staged config is committed here.
      phase_d = '0;
      if (accept) begin
        div_d  = cfg_div;
        high_d = cfg_high;
      end else if (stg_valid_q) begin
        div_d  = stg_div_q;
        high_d = stg_high_q;
      end
      stg_valid_d = 1'b0;
      state_d     = (active_q && halt_req) ? ST_HALTED : ST_RUN;
    end else begin
      phase_d = phase_q + ONE;
      if (accept) begin
        stg_valid_d = 1'b1;
        stg_div_d   = cfg_div;
        stg_high_d  = cfg_high;
      end
    end

    running_d      = (state_d != ST_HALTED);
    halt_ack_d     = (state_d == ST_HALTED);
    clk_en_d       = running_d && (phase_d < high_d);
    period_start_d = running_d && (phase_d == '0);
    cfg_ready_d    = !stg_valid_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_RUN;
      phase_q      <= '0;
      div_q        <= DIV_RST;
      high_q       <= HIGH_RST;
      stg_valid_q  <= 1'b0;
      stg_div_q    <= '0;
      stg_high_q   <= '0;
      active_q     <= 1'b0;
      clk_en       <= 1'b0;
      period_start <= 1'b0;
      running      <= 1'b0;
      halt_ack     <= 1'b0;
      cfg_ready    <= 1'b1;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      div_q        <= div_d;
      high_q       <= high_d;
      stg_valid_q  <= stg_valid_d;
      stg_div_q    <= stg_div_d;
      stg_high_q   <= stg_high_d;
      active_q     <= 1'b1;
      clk_en       <= clk_en_d;
      period_start <= period_start_d;
      running      <= running_d;
      halt_ack     <= halt_ack_d;
      cfg_ready    <= cfg_ready_d;
    end
  end

endmodule

// File: tb/tb_clk_en_ctrl.sv
// Testbench for clk_en_ctrl. Each test task queues the expected output vector
// {clk_en, period_start, running, halt_ack, cfg_ready} for every cycle it
// drives, then pops and compares one entry per observed cycle.
// Inputs change and outputs are sampled 1 time unit after each rising edge.

module tb_clk_en_ctrl;

  localparam int CNT_W = 16;
  localparam logic [4:0] HALTED_V = 5'b00011;
  localparam logic [4:0] RESET_V  = 5'b00001;

  logic             clk;
  logic             rst_n;
  logic             cfg_valid;
  logic             cfg_ready;
  logic [CNT_W-1:0] cfg_div;
  logic [CNT_W-1:0] cfg_high;
  logic             halt_req;
  logic             halt_ack;
  logic             step_req;
  logic             clk_en;
  logic             period_start;
  logic             running;

  logic [4:0] obs;
  logic [4:0] exp_v;
  logic [4:0] exp_q[$];
  int checks;
  int failures;

  assign obs = {clk_en, period_start, running, halt_ack, cfg_ready};

  clk_en_ctrl #(
    .CNT_W(CNT_W),
    .DEFAULT_DIV(4),
    .DEFAULT_HIGH(2)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .cfg_div(cfg_div),
    .cfg_high(cfg_high),
    .halt_req(halt_req),
    .halt_ack(halt_ack),
    .step_req(step_req),
    .clk_en(clk_en),
    .period_start(period_start),
    .running(running)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected vector for a running cycle in phase p with the given HIGH.
  function automatic logic [4:0] run_pat(int p, int high, bit rdy);
    return {(p < high), (p == 0), 1'b1, 1'b0, rdy};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_cfg(bit v, int d, int h);
    cfg_valid = v;
    cfg_div   = CNT_W'(d);
    cfg_high  = CNT_W'(h);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int k = 0; k < 2; k++) begin
      exp_q.push_back(RESET_V);
      cyc();
      exp_v = exp_q.pop_front();
      checks++;
      if (obs !== exp_v) begin
        failures++;
        $display("[TB] FAIL reset k=%0d got=%b want=%b", k, obs, exp_v);
      end
    end
    rst_n = 1'b1;
  endtask

  // Default DIV=4, HIGH=2 straight out of reset.
  task automatic test_defaults();
    for (int k = 0; k < 15; k++) exp_q.push_back(run_pat(k % 5, 2, 1'b1));
    for (int k = 0; k < 15; k++) begin
      cyc();
      exp_v = exp_q.pop_front();
      checks++;
      if (obs !== exp_v) begin
        failures++;
        $display("[TB] FAIL defaults k=%0d got=%b want=%b", k, obs, exp_v);
      end
    end
  endtask

  // Config offered in phase 1 is staged and committed at the next phase 0.
  task automatic test_cfg_mid_period();
    for (int k = 0; k < 14; k++) begin
      if (k < 2)      exp_q.push_back(run_pat(k, 2, 1'b1));
      else if (k < 5) exp_q.push_back(run_pat(k, 2, 1'b0));
      else            exp_q.push_back(run_pat((k - 5) % 3, 1, 1'b1));
    end
    for (int k = 0; k < 14; k++) begin
      cyc();
      exp_v = exp_q.pop_front();
      checks++;
      if (obs !== exp_v) begin
        failures++;
        $display("[TB] FAIL cfg_mid k=%0d got=%b want=%b", k, obs, exp_v);
      end
      if (k == 1) drive_cfg(1'b1, 2, 1);
      if (k == 2) drive_cfg(1'b0, 0, 0);
    end
  endtask

  // Config offered in the last phase applies to the very next period.
  task automatic test_cfg_boundary();
    for (int k = 0; k < 8; k++) begin
      if (k < 3) exp_q.push_back(run_pat(k, 1, 1'b1));
      else       exp_q.push_back(run_pat(k - 3, 2, 1'b1));
    end
    for (int k = 0; k < 8; k++) begin
      cyc();
      exp_v = exp_q.pop_front();
      checks++;
      if (obs !== exp_v) begin
        failures++;
        $display("[TB] FAIL cfg_boundary k=%0d got=%b want=%b", k, obs, exp_v);
      end
      if (k == 2) drive_cfg(1'b1, 4, 2);
      if (k == 3) drive_cfg(1'b0, 0, 0);
    end
  endtask

  task automatic test_halt();
    for (int k = 0; k < 13; k++) begin
      if (k < 5)      exp_q.push_back(run_pat(k, 2, 1'b1));
      else if (k < 8) exp_q.push_back(HALTED_V);
      else            exp_q.push_back(run_pat(k - 8, 2, 1'b1));
    end
    for (int k = 0; k < 13; k++) begin
      cyc();
      exp_v = exp_q.pop_front();
      checks++;
      if (obs !== exp_v) begin
        failures++;
        $display("[TB] FAIL halt k=%0d got=%b want=%b", k, obs, exp_v);
      end
      if (k == 2) halt_req = 1'b1;
      if (k == 7) halt_req = 1'b0;
    end
  endtask

  // One step period; a second step_req during the step is ignored.
  task automatic test_step();
    for (int k = 0; k < 15; k++) begin
      if (k < 5)       exp_q.push_back(run_pat(k, 2, 1'b1));
      else if (k < 7)  exp_q.push_back(HALTED_V);
      else if (k < 12) exp_q.push_back(run_pat(k - 7, 2, 1'b1));
      else             exp_q.push_back(HALTED_V);
    end
    for (int k = 0; k < 15; k++) begin
      cyc();
      exp_v = exp_q.pop_front();
      checks++;
      if (obs !== exp_v) begin
        failures++;
        $display("[TB] FAIL step k=%0d got=%b want=%b", k, obs, exp_v);
      end
      if (k == 1) halt_req = 1'b1;
      if (k == 6) step_req = 1'b1;
      if (k == 7) step_req = 1'b0;
      if (k == 8) step_req = 1'b1;
      if (k == 9) step_req = 1'b0;
    end
  endtask

  // HIGH=0 written while halted; used by the first period after release.
  task automatic test_high_zero();
    for (int k = 0; k < 12; k++) begin
      if (k < 2) exp_q.push_back(HALTED_V);
      else       exp_q.push_back(run_pat((k - 2) % 5, 0, 1'b1));
    end
    for (int k = 0; k < 12; k++) begin
      cyc();
      exp_v = exp_q.pop_front();
      checks++;
      if (obs !== exp_v) begin
        failures++;
        $display("[TB] FAIL high_zero k=%0d got=%b want=%b", k, obs, exp_v);
      end
      if (k == 0) drive_cfg(1'b1, 4, 0);
      if (k == 1) begin
        drive_cfg(1'b0, 0, 0);
        halt_req = 1'b0;
      end
    end
  endtask

  // Entered in the last phase of a DIV=4 period: HIGH>DIV keeps clk_en high.
  task automatic test_high_gt_div();
    drive_cfg(1'b1, 3, 7);
    for (int k = 0; k < 12; k++) exp_q.push_back(run_pat(k % 4, 7, 1'b1));
    for (int k = 0; k < 12; k++) begin
      cyc();
      exp_v = exp_q.pop_front();
      checks++;
      if (obs !== exp_v) begin
        failures++;
        $display("[TB] FAIL high_gt_div k=%0d got=%b want=%b", k, obs, exp_v);
      end
      if (k == 0) drive_cfg(1'b0, 0, 0);
    end
  endtask

  // Entered in the last phase of a DIV=3 period: DIV=0 gives a 1-cycle period.
  task automatic test_div_zero();
    drive_cfg(1'b1, 0, 1);
    for (int k = 0; k < 8; k++) exp_q.push_back(run_pat(0, 1, 1'b1));
    for (int k = 0; k < 8; k++) begin
      cyc();
      exp_v = exp_q.pop_front();
      checks++;
      if (obs !== exp_v) begin
        failures++;
        $display("[TB] FAIL div_zero k=%0d got=%b want=%b", k, obs, exp_v);
      end
      if (k == 0) drive_cfg(1'b0, 0, 0);
    end
  endtask

  // Reset in phase 3 with a staged config; the staged config must be dropped.
  task automatic test_reset_mid();
    drive_cfg(1'b1, 4, 2);
    for (int k = 0; k < 4; k++) exp_q.push_back(run_pat(k, 2, (k < 2)));
    for (int k = 0; k < 4; k++) begin
      cyc();
      exp_v = exp_q.pop_front();
      checks++;
      if (obs !== exp_v) begin
        failures++;
        $display("[TB] FAIL reset_mid_pre k=%0d got=%b want=%b", k, obs, exp_v);
      end
      if (k == 0) drive_cfg(1'b0, 0, 0);
      if (k == 1) drive_cfg(1'b1, 2, 1);
      if (k == 2) drive_cfg(1'b0, 0, 0);
    end
    rst_n = 1'b0;
    exp_q.push_back(RESET_V);
    #1;
    exp_v = exp_q.pop_front();
    checks++;
    if (obs !== exp_v) begin
      failures++;
      $display("[TB] FAIL reset_mid_async got=%b want=%b", obs, exp_v);
    end
    cyc();
    cyc();
    rst_n = 1'b1;
    for (int k = 0; k < 10; k++) exp_q.push_back(run_pat(k % 5, 2, 1'b1));
    for (int k = 0; k < 10; k++) begin
      cyc();
      exp_v = exp_q.pop_front();
      checks++;
      if (obs !== exp_v) begin
        failures++;
        $display("[TB] FAIL reset_mid_post k=%0d got=%b want=%b", k, obs, exp_v);
      end
    end
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    rst_n     = 1'b1;
    cfg_valid = 1'b0;
    cfg_div   = '0;
    cfg_high  = '0;
    halt_req  = 1'b0;
    step_req  = 1'b0;
    #1;
    test_reset();
    test_defaults();
    test_cfg_mid_period();
    test_cfg_boundary();
    test_halt();
    test_step();
    test_high_zero();
    test_high_gt_div();
    test_div_zero();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout checks=%0d", checks);
    $fatal(1, "[TB] simulation time limit reached");
  end

endmodule

// File: doc/clk_en_ctrl.md
Name: clk_en_ctrl

Overview:
- Runtime-programmable controller for the core clock-enable.
- Generates a periodic single-clock enable (clk_en) with software-set period and high time.
- Supports safe reconfiguration only at period boundaries, plus a debug halt/single-step handshake.
- Sits between the CSR/debug logic and every core stage gated by clk_en; whole core runs on clk.

Parameters:
- CNT_W, 16: width of the period and high-time fields and of the phase counter.
- DEFAULT_DIV, 4: reset value of DIV. Period = DIV+1 clk cycles.
- DEFAULT_HIGH, 2: reset value of HIGH, the number of leading enabled phases per period.

Ports:
- clk  in  1  reference clock.
- rst_n  in  1  asynchronous active-low reset.
- cfg_valid  in  1  new configuration offered.
- cfg_ready  out  1  controller can accept a configuration.
- cfg_div  in  CNT_W  requested DIV.
- cfg_high  in  CNT_W  requested HIGH.
- halt_req  in  1  level; request halt at the end of the current period.
- halt_ack  out  1  high while halted.
- step_req  in  1  pulse; run exactly one period while halted.
- clk_en  out  1  core clock enable.
- period_start  out  1  one-cycle pulse in phase 0 of each executed period.
- running  out  1  high while periods are being executed.

Behaviour:
- Outputs are registered. Each output reflects the phase p (0..DIV) of the cycle in which it is observed.
- Reset values (while rst_n low):
  - clk_en=0, period_start=0, halt_ack=0, running=0, cfg_ready=1.
  - DIV=DEFAULT_DIV, HIGH=DEFAULT_HIGH, no staged config, state RUN.
- First phase 0 occurs in the first cycle after the first rising clk edge with rst_n high.
- Phase sequence: phase increments each cycle and wraps from DIV to 0.
- clk_en rule: clk_en=1 in phase p iff p<HIGH and state is RUN or STEP.
  - HIGH=0: clk_en never asserts.
  - HIGH>DIV: clk_en stays constantly 1.
  - DIV=0: period is 1 cycle; period_start is constant 1 while running.
- Comparisons are unsigned, CNT_W bits.
- Configuration handshake:
  - A config is accepted on a cycle where cfg_valid && cfg_ready.
  - RUN/STEP: the config is staged and cfg_ready drops the next cycle. The staged DIV/HIGH take effect at the next phase 0. cfg_ready returns high in that phase-0 cycle.
  - HALTED: the config is applied directly and cfg_ready stays high.
  - A config accepted in phase DIV applies to the immediately following period.
- State machine:
  - RUN: executes periods. If halt_req=1 in a phase-DIV cycle, go to HALTED for the next cycle; otherwise continue. halt_req raised mid-period lets the current period complete.
  - HALTED: clk_en=0, running=0, halt_ack=1, phase held at 0.
    - halt_req=0 → RUN; next cycle is phase 0 with period_start=1.
    - Else if step_req=1 → STEP; next cycle is phase 0.
    - If halt_req falls in the same cycle as step_req, the release wins: go to RUN, step ignored.
  - STEP: runs exactly one period with halt_ack=0 and running=1. After phase DIV → HALTED, or → RUN if halt_req=0.
- step_req is ignored outside HALTED.
- running is 1 in RUN and STEP.
- Reset mid-operation immediately forces reset values. Any staged config is discarded.

Test Plan:
- Defaults, no requests: clk_en = 1,1,0,0,0 repeating; period_start high in every 5th cycle starting with the first post-reset cycle; running=1; halt_ack=0.
- Config mid-period: cfg_div=2, cfg_high=1 offered in phase 1 → accepted, cfg_ready=0; the current period finishes as 1,1,0,0,0; then pattern is 1,0,0 repeating; cfg_ready returns 1 at the new phase 0.
- Halt: halt_req set in phase 2 → phases 2–4 complete; halt_ack=1 and clk_en=0 from the next cycle. Release halt_req → next cycle is phase 0 with clk_en=1 and period_start=1.
- Single step while halted: one-cycle step_req → exactly 5 cycles with halt_ack=0 and clk_en 1,1,0,0,0; then halt_ack=1. A second step_req issued during the step is ignored.
- Boundary values:
  - cfg_high=0 → clk_en never 1.
  - cfg_div=3, cfg_high=7 → clk_en constant 1, period_start every 4 cycles.
  - cfg_div=0, cfg_high=1 → clk_en and period_start constant 1.
  - A config applied while halted is used by the first period after release.
- Reset mid-operation: assert rst_n=0 in phase 3 with a config staged → all outputs reach reset values immediately. After release, the default 1,1,0,0,0 pattern resumes and the staged config is never applied.
